// File: rtl/u409_ac_pkg.sv
// Shared AUTOCONFIG constants and FSM state type for the U409 configurator.
package u409_ac_pkg;

    localparam logic [15:0] AC_SPACE = 16'h00E8;

    localparam logic [6:0] AC_OFS_TYPE_H  = 7'h00;
    localparam logic [6:0] AC_OFS_TYPE_L  = 7'h02;
    localparam logic [6:0] AC_OFS_PROD_H  = 7'h04;
    localparam logic [6:0] AC_OFS_PROD_L  = 7'h06;
    localparam logic [6:0] AC_OFS_MANUF0  = 7'h10;
    localparam logic [6:0] AC_OFS_MANUF1  = 7'h12;
    localparam logic [6:0] AC_OFS_MANUF2  = 7'h14;
    localparam logic [6:0] AC_OFS_MANUF3  = 7'h16;
    localparam logic [6:0] AC_OFS_BASE    = 7'h48;
    localparam logic [6:0] AC_OFS_SHUTUP  = 7'h4C;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        DONE
    } ac_state_e;

endpackage

// File: rtl/u409_ac_rom.sv
// Combinational AUTOCONFIG nibble lookup: (board index, offset) -> read nibble.
module u409_ac_rom
    import u409_ac_pkg::*;
#(
    parameter int unsigned                  NUM_BOARDS = 3,
    parameter int unsigned                  IW         = 2,
    parameter logic [15:0]                  MANUF_ID   = 16'h082C,
    parameter logic [8*NUM_BOARDS-1:0]      BOARD_TYPE = 24'hE2E1E0,
    parameter logic [8*NUM_BOARDS-1:0]      BOARD_PROD = 24'h030201
) (
    input  logic [IW-1:0] idx,
    input  logic [6:0]    ofs,
    output logic [3:0]    nibble
);

    logic [7:0] er_type;
    logic [7:0] er_prod;

    always_comb begin
        er_type = 8'h00;
        er_prod = 8'h00;
        for (int b = 0; b < int'(NUM_BOARDS); b++) begin
            if (idx == IW'(b)) begin
                er_type = BOARD_TYPE[8*b +: 8];
                er_prod = BOARD_PROD[8*b +: 8];
            end
        end
    end

    // Only er_type is served true; everything else reads back inverted.
    always_comb begin
        nibble = 4'hF;
        case (ofs)
            AC_OFS_TYPE_H: nibble = er_type[7:4];
            AC_OFS_TYPE_L: nibble = er_type[3:0];
            AC_OFS_PROD_H: nibble = ~er_prod[7:4];
            AC_OFS_PROD_L: nibble = ~er_prod[3:0];
            AC_OFS_MANUF0: nibble = ~MANUF_ID[15:12];
            AC_OFS_MANUF1: nibble = ~MANUF_ID[11:8];
            AC_OFS_MANUF2: nibble = ~MANUF_ID[7:4];
            AC_OFS_MANUF3: nibble = ~MANUF_ID[3:0];
            default:       nibble = 4'hF;
        endcase
    end

endmodule

// File: rtl/u409_autoconfig_chain.sv
// Zorro II AUTOCONFIG responder presenting NUM_BOARDS logical boards in turn at $E80000.
// Define AC_SHUTUP_EN to honour writes to the shut-up register at $E8004C.
module u409_autoconfig_chain
    import u409_ac_pkg::*;
#(
    parameter int unsigned              NUM_BOARDS = 3,
    parameter logic [15:0]              MANUF_ID   = 16'h082C,
    parameter logic [8*NUM_BOARDS-1:0]  BOARD_TYPE = 24'hE2E1E0,
    parameter logic [8*NUM_BOARDS-1:0]  BOARD_PROD = 24'h030201,
    parameter int unsigned              TA_WAIT    = 1
) (
    input  logic                      CLK40,
    input  logic                      RESET,
    input  logic [31:1]               A,
    input  logic                      nTS,
    input  logic                      nTIP,
    input  logic                      RnW,
    input  logic [3:0]                D_IN,
    input  logic [NUM_BOARDS-1:0]     BOARD_EN,
    output logic [3:0]                D_OUT,
    output logic                      D_OE,
    output logic                      nTA,
    output logic [4*NUM_BOARDS-1:0]   BASE,
    output logic [NUM_BOARDS-1:0]     BOARD_VALID,
    output logic                      CONFIGED
);

    localparam int unsigned       IW       = $clog2(NUM_BOARDS + 1);
    localparam logic [IW-1:0]     NO_BOARD = IW'(NUM_BOARDS);
    localparam logic [2:0]        WAIT_LAST = 3'(TA_WAIT - 1);

    // Lowest enabled board at or above start; NO_BOARD when none remain.
    function automatic logic [IW-1:0] find_en(input int start, input logic [NUM_BOARDS-1:0] en);
        logic [IW-1:0] r;
        r = NO_BOARD;
        for (int j = int'(NUM_BOARDS) - 1; j >= 0; j--) begin
            if (j >= start && en[j]) r = IW'(j);
        end
        return r;
    endfunction

    ac_state_e                state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [6:0]               ofs_q;
    logic                     rnw_q;
    logic [IW-1:0]            idx_q, nxt_idx;
    logic                     configed_q, configed_d;
    logic [4*NUM_BOARDS-1:0]  base_q, base_d;
    logic [NUM_BOARDS-1:0]    valid_q, valid_d;
    logic                     hit, latch, wr_ack, base_wr, shut_wr, advance;
    logic [3:0]               rom_nibble;
    logic                     ack_st, rd_st;
    logic                     unused_a;

    assign unused_a = ^A[15:7];

    assign hit = (A[31:16] == AC_SPACE) && !nTS && !configed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    latch   = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = (TA_WAIT == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = ACK;
                else                    cnt_d   = cnt_q + 3'd1;
            end
            ACK: state_d = DONE;
            DONE: begin
                if (hit) begin
                    latch   = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = (TA_WAIT == 0) ? ACK : WAIT;
                end else if (nTIP || !nTS) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ack  = (state_q == ACK) && !rnw_q;
    assign base_wr = wr_ack && (ofs_q == AC_OFS_BASE);
`ifdef AC_SHUTUP_EN
    assign shut_wr = wr_ack && (ofs_q == AC_OFS_SHUTUP);
`else
    assign shut_wr = 1'b0;
`endif
    assign advance = base_wr || shut_wr;
    assign nxt_idx = find_en(int'(idx_q) + 1, BOARD_EN);

    // All-disabled chains complete on the first cycle out of reset.
    assign configed_d = configed_q || (idx_q == NO_BOARD) || (advance && (nxt_idx == NO_BOARD));

    always_comb begin
        base_d  = base_q;
        valid_d = valid_q;
        for (int b = 0; b < int'(NUM_BOARDS); b++) begin
            if (idx_q == IW'(b)) begin
                if (base_wr) begin
                    base_d[4*b +: 4] = D_IN;
                    valid_d[b]       = 1'b1;
                end
                if (shut_wr) begin
                    base_d[4*b +: 4] = 4'h0;
                    valid_d[b]       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            ofs_q      <= 7'h00;
            rnw_q      <= 1'b1;
            idx_q      <= find_en(0, BOARD_EN);
            configed_q <= 1'b0;
            base_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            configed_q <= configed_d;
            base_q     <= base_d;
            valid_q    <= valid_d;
            if (latch) begin
                ofs_q <= {A[6:1], 1'b0};
                rnw_q <= RnW;
            end
            if (advance) idx_q <= nxt_idx;
        end
    end

    u409_ac_rom #(
        .NUM_BOARDS (NUM_BOARDS),
        .IW         (IW),
        .MANUF_ID   (MANUF_ID),
        .BOARD_TYPE (BOARD_TYPE),
        .BOARD_PROD (BOARD_PROD)
    ) u_rom (
        .idx    (idx_q),
        .ofs    (ofs_q),
        .nibble (rom_nibble)
    );

    // RESET gates the bus strobes so a pending acknowledge is dropped at once.
    assign ack_st = (state_q == ACK) && !RESET;
    assign rd_st  = ((state_q == WAIT) || (state_q == ACK)) && rnw_q && !RESET;

    assign nTA         = !ack_st;
    assign D_OE        = rd_st;
    assign D_OUT       = rd_st ? rom_nibble : 4'hF;
    assign BASE        = base_q;
    assign BOARD_VALID = valid_q;
    assign CONFIGED    = configed_q;

endmodule

// File: tb/tb_u409_autoconfig_chain.sv
// Directed self-checking bench for u409_autoconfig_chain (default parameters, TA_WAIT=1).
module tb_u409_autoconfig_chain;

    logic        CLK40 = 1'b0;
    logic        RESET;
    logic [31:1] A;
    logic        nTS, nTIP, RnW;
    logic [3:0]  D_IN;
    logic [2:0]  BOARD_EN;
    logic [3:0]  D_OUT;
    logic        D_OE, nTA;
    logic [11:0] BASE;
    logic [2:0]  BOARD_VALID;
    logic        CONFIGED;

    int checks = 0;
    int passed = 0;

    int         ta_cnt, ta_k;
    logic [3:0] rd;
    logic       oe_ack, oe_any, cfg_ack, cfg_after;

    always #5 CLK40 = ~CLK40;

    u409_autoconfig_chain dut (
        .CLK40       (CLK40),
        .RESET       (RESET),
        .A           (A),
        .nTS         (nTS),
        .nTIP        (nTIP),
        .RnW         (RnW),
        .D_IN        (D_IN),
        .BOARD_EN    (BOARD_EN),
        .D_OUT       (D_OUT),
        .D_OE        (D_OE),
        .nTA         (nTA),
        .BASE        (BASE),
        .BOARD_VALID (BOARD_VALID),
        .CONFIGED    (CONFIGED)
    );

    task automatic step();
        @(posedge CLK40);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] en);
        RESET = 1'b1; BOARD_EN = en;
        A = '0; nTS = 1'b1; nTIP = 1'b1; RnW = 1'b1; D_IN = 4'h0;
        repeat (3) step();
        RESET = 1'b0;
    endtask

    // Drives one transfer and records what the responder did; judging is left to the caller.
    task automatic bus_cycle(input logic [31:0] addr, input logic rnw, input logic [3:0] din);
        logic [31:0] a_full;
        a_full = addr;
        A = a_full[31:1]; RnW = rnw; D_IN = din; nTS = 1'b0; nTIP = 1'b0;
        ta_cnt = 0; ta_k = -1; rd = 4'hF; oe_ack = 1'b0; oe_any = 1'b0;
        cfg_ack = 1'b0; cfg_after = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) nTS = 1'b1;
            oe_any = oe_any | D_OE;
            if (!nTA) begin
                ta_cnt++;
                if (ta_k < 0) begin
                    ta_k = k; rd = D_OUT; oe_ack = D_OE; cfg_ack = CONFIGED;
                end
            end
            if (ta_k > 0 && k == ta_k + 1) cfg_after = CONFIGED;
        end
        nTIP = 1'b1; A = '0; RnW = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset(3'b111);
        checks++; if ({nTA, D_OE, D_OUT} !== 6'b1_0_1111)
            $display("FAIL reset_bus nTA/D_OE/D_OUT got %b required 101111", {nTA, D_OE, D_OUT});
        else passed++;
        checks++; if ({BASE, BOARD_VALID, CONFIGED} !== 16'h0000)
            $display("FAIL reset_state BASE/VALID/CONFIGED got %h required 0000",
                     {BASE, BOARD_VALID, CONFIGED});
        else passed++;
    endtask

    task automatic test_type_read();
        logic [31:0] addrs [3] = '{32'h00E80000, 32'h00E80002, 32'h00E80006};
        logic [3:0]  exps  [3] = '{4'hE, 4'h0, 4'hE};
        do_reset(3'b111);
        for (int i = 0; i < 3; i++) begin
            bus_cycle(addrs[i], 1'b1, 4'h0);
            checks++; if (rd !== exps[i] || oe_ack !== 1'b1)
                $display("FAIL type_read[%0d] data/oe got %h/%b required %h/1", i, rd, oe_ack, exps[i]);
            else passed++;
            checks++; if (ta_cnt !== 1 || ta_k !== 2)
                $display("FAIL type_read_ta[%0d] count/cycle got %0d/%0d required 1/2", i, ta_cnt, ta_k);
            else passed++;
        end
    endtask

    task automatic test_base_writes();
        do_reset(3'b111);
        for (int i = 0; i < 3; i++) begin
            bus_cycle(32'h00E80048, 1'b0, 4'(8 + i));
            checks++; if (ta_cnt !== 1)
                $display("FAIL base_write_ta[%0d] got %0d required 1", i, ta_cnt);
            else passed++;
        end
        checks++; if ({cfg_ack, cfg_after} !== 2'b01)
            $display("FAIL configed_timing ack/after got %b required 01", {cfg_ack, cfg_after});
        else passed++;
        checks++; if (BASE !== 12'hA98 || BOARD_VALID !== 3'b111 || CONFIGED !== 1'b1)
            $display("FAIL base_values BASE/VALID/CFG got %h/%b/%b required a98/111/1",
                     BASE, BOARD_VALID, CONFIGED);
        else passed++;
        bus_cycle(32'h00E80000, 1'b1, 4'h0);
        checks++; if (ta_cnt !== 0 || oe_any !== 1'b0)
            $display("FAIL post_config_read ta/oe got %0d/%b required 0/0", ta_cnt, oe_any);
        else passed++;
    endtask

    task automatic test_skip();
        do_reset(3'b101);
        bus_cycle(32'h00E80002, 1'b1, 4'h0);
        checks++; if (rd !== 4'h0)
            $display("FAIL skip_board0_type got %h required 0", rd);
        else passed++;
        bus_cycle(32'h00E80048, 1'b0, 4'h5);
        bus_cycle(32'h00E80000, 1'b1, 4'h0);
        checks++; if (rd !== 4'hE)
            $display("FAIL skip_board2_type_h got %h required e", rd);
        else passed++;
        bus_cycle(32'h00E80002, 1'b1, 4'h0);
        checks++; if (rd !== 4'h2)
            $display("FAIL skip_board2_type_l got %h required 2", rd);
        else passed++;
        bus_cycle(32'h00E80048, 1'b0, 4'h6);
        checks++; if (CONFIGED !== 1'b1 || BASE !== 12'h605 || BOARD_VALID !== 3'b101)
            $display("FAIL skip_done CFG/BASE/VALID got %b/%h/%b required 1/605/101",
                     CONFIGED, BASE, BOARD_VALID);
        else passed++;
        do_reset(3'b000);
        checks++; if (CONFIGED !== 1'b0)
            $display("FAIL all_disabled_at_release got %b required 0", CONFIGED);
        else passed++;
        step();
        checks++; if (CONFIGED !== 1'b1)
            $display("FAIL all_disabled_next_cycle got %b required 1", CONFIGED);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic ta_seen;
        do_reset(3'b111);
        bus_cycle(32'h00E80048, 1'b0, 4'h7);
        A = 31'h00E80048 >> 1; RnW = 1'b0; D_IN = 4'h3; nTS = 1'b0; nTIP = 1'b0;
        step();
        nTS = 1'b1;
        RESET = 1'b1;
        ta_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            ta_seen = ta_seen | !nTA;
        end
        RESET = 1'b0; nTIP = 1'b1; A = '0; RnW = 1'b1;
        step();
        checks++; if (ta_seen !== 1'b0)
            $display("FAIL reset_mid_no_ta got %b required 0", ta_seen);
        else passed++;
        checks++; if (BASE !== 12'h000 || CONFIGED !== 1'b0 || BOARD_VALID !== 3'b000)
            $display("FAIL reset_mid_clear BASE/CFG/VALID got %h/%b/%b required 000/0/000",
                     BASE, CONFIGED, BOARD_VALID);
        else passed++;
        bus_cycle(32'h00E80002, 1'b1, 4'h0);
        checks++; if (rd !== 4'h0 || ta_cnt !== 1)
            $display("FAIL reset_mid_board0 data/ta got %h/%0d required 0/1", rd, ta_cnt);
        else passed++;
    endtask

    task automatic test_shutup();
        logic [3:0] exp_lo;
`ifdef AC_SHUTUP_EN
        exp_lo = 4'h1;
`else
        exp_lo = 4'h0;
`endif
        do_reset(3'b111);
        bus_cycle(32'h00E8004C, 1'b0, 4'h3);
        checks++; if (ta_cnt !== 1)
            $display("FAIL shutup_ta got %0d required 1", ta_cnt);
        else passed++;
        checks++; if (BOARD_VALID !== 3'b000 || BASE !== 12'h000)
            $display("FAIL shutup_state VALID/BASE got %b/%h required 000/000", BOARD_VALID, BASE);
        else passed++;
        bus_cycle(32'h00E80002, 1'b1, 4'h0);
        checks++; if (rd !== exp_lo)
            $display("FAIL shutup_index type_l got %h required %h", rd, exp_lo);
        else passed++;
    endtask

    task automatic test_manuf();
        logic [31:0] addrs [4] = '{32'h00E80010, 32'h00E80012, 32'h00E80016, 32'h00E80030};
        logic [3:0]  exps  [4] = '{4'hF, 4'h7, 4'h3, 4'hF};
        do_reset(3'b111);
        for (int i = 0; i < 4; i++) begin
            bus_cycle(addrs[i], 1'b1, 4'h0);
            checks++; if (rd !== exps[i] || ta_cnt !== 1)
                $display("FAIL manuf_read[%0d] data/ta got %h/%0d required %h/1",
                         i, rd, ta_cnt, exps[i]);
            else passed++;
        end
        bus_cycle(32'h00DC0000, 1'b1, 4'h0);
        checks++; if (ta_cnt !== 0 || oe_any !== 1'b0)
            $display("FAIL non_e8_access ta/oe got %0d/%b required 0/0", ta_cnt, oe_any);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_type_read();
        test_base_writes();
        test_skip();
        test_reset_mid();
        test_shutup();
        test_manuf();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
